// File: rtl/sobel_window_buffer_if.sv
// Pixel-in / window-out stream bundle for the Sobel 3x3 window buffer.
// Latency: none (wires only).
// Backpressure: valid/ready on both the pixel and the window side.
interface sobel_window_buffer_if #(
  parameter int PIXEL_WIDTH = 8
);
  logic [PIXEL_WIDTH-1:0]   px_i;
  logic                     px_valid_i;
  logic                     px_ready_o;
  logic [9*PIXEL_WIDTH-1:0] window_o;
  logic                     window_valid_o;
  logic                     window_ready_i;
  logic                     frame_done_o;

  // Pixel source and window consumer side
  modport master (
    output px_i, px_valid_i, window_ready_i,
    input  px_ready_o, window_o, window_valid_o, frame_done_o
  );

  // Window buffer side
  modport slave (
    input  px_i, px_valid_i, window_ready_i,
    output px_ready_o, window_o, window_valid_o, frame_done_o
  );
endinterface

// File: rtl/sobel_window_buffer.sv
// Raster pixel stream to 3x3 neighbourhood windows using two line buffers.
// Latency: 1 cycle from accept of the window's newest pixel to window_valid_o.
// Backpressure: px_ready_o = !window_valid_o || window_ready_i (pass-through).
module sobel_window_buffer #(
  parameter int PIXEL_WIDTH = 8,
  parameter int IMG_WIDTH   = 16,
  parameter int IMG_HEIGHT  = 16
) (
  input  logic                 clk_i,
  input  logic                 nreset_i,
  input  logic                 clear_i,
  sobel_window_buffer_if.slave bus
);
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  // line_a holds row r-2, line_b holds row r-1, indexed by column
  logic [PIXEL_WIDTH-1:0] line_a [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0] line_b [IMG_WIDTH];

  // 3x3 shift window, index k = 3*row_in_window + col_in_window
  logic [PIXEL_WIDTH-1:0] sr      [9];
  logic [PIXEL_WIDTH-1:0] sr_next [9];
  logic [9*PIXEL_WIDTH-1:0] win_next;

  logic [9*PIXEL_WIDTH-1:0] win_q;
  logic win_vld_q;
  logic done_q;

  logic px_rdy;
  logic accept;
  logic emit;
  logic col_last;
  logic row_last;

  assign px_rdy   = !win_vld_q || bus.window_ready_i;
  assign accept   = bus.px_valid_i && px_rdy && !clear_i;
  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);
  // Border positions never produce a window; stale columns after a row wrap
  // are masked here rather than by clearing the shift window.
  assign emit     = accept && (row >= RW'(2)) && (col >= CW'(2));

  assign bus.px_ready_o     = px_rdy;
  assign bus.window_o       = win_q;
  assign bus.window_valid_o = win_vld_q;
  assign bus.frame_done_o   = done_q;

  // Next shift window: shift left one column, load the new right column
  always_comb begin
    for (int k = 0; k < 9; k++) sr_next[k] = sr[k];
    for (int i = 0; i < 3; i++) begin
      sr_next[3*i]     = sr[3*i+1];
      sr_next[3*i + 1] = sr[3*i+2];
    end
    sr_next[2] = line_a[col];
    sr_next[5] = line_b[col];
    sr_next[8] = bus.px_i;
    win_next = '0;
    for (int k = 0; k < 9; k++) win_next[k*PIXEL_WIDTH +: PIXEL_WIDTH] = sr_next[k];
  end

  // Line buffers and shift window advance only on an accepted pixel
  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      for (int i = 0; i < IMG_WIDTH; i++) begin
        line_a[i] <= '0;
        line_b[i] <= '0;
      end
      for (int k = 0; k < 9; k++) sr[k] <= '0;
    end else if (accept) begin
      line_a[col] <= line_b[col];
      line_b[col] <= bus.px_i;
      for (int k = 0; k < 9; k++) sr[k] <= sr_next[k];
    end
  end

  // Raster counters, output window register and frame-done pulse
  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      col       <= '0;
      row       <= '0;
      win_q     <= '0;
      win_vld_q <= 1'b0;
      done_q    <= 1'b0;
    end else if (clear_i) begin
      col       <= '0;
      row       <= '0;
      win_vld_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= accept && row_last && col_last;
      if (accept) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      // A same-cycle handshake and new window keeps valid high with no bubble
      if (emit) begin
        win_vld_q <= 1'b1;
        win_q     <= win_next;
      end else if (bus.window_ready_i) begin
        win_vld_q <= 1'b0;
      end
    end
  end
endmodule
